// File: rtl/titan_if_stage_pkg.sv
// titan_if_stage_pkg: shared fetch-stage definitions (NOP encoding, default reset address, FSM states, IF/ID payload)
package titan_if_stage_pkg;
  localparam logic [31:0] NOP = 32'h0000_0013;
  localparam logic [31:0] DEFAULT_RESET_ADDR = 32'h8000_0000;
  typedef enum logic [2:0] {S_FETCH, S_HOLD, S_ABORT, S_MISALIGN, S_IDLE} if_state_e;
  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
    logic        mis;
    logic        fault;
  } ifid_t;
  localparam ifid_t BUBBLE = '{pc: 32'h0, instr: NOP, mis: 1'b0, fault: 1'b0};
  function automatic if_state_e entry_state(input logic [31:0] addr);
    return (addr[1:0] != 2'b00) ? S_MISALIGN : S_FETCH;
  endfunction
endpackage

// File: rtl/titan_ifid_register.sv
// titan_ifid_register: IF/ID pipeline register; flush loads a bubble and wins over stall, stall holds.
module titan_ifid_register
  import titan_if_stage_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic        flush,
  input  logic [31:0] pc_i,
  input  logic [31:0] instruction_i,
  input  logic        inst_addr_misaligned_i,
  input  logic        inst_access_fault_i,
  output logic [31:0] pc_o,
  output logic [31:0] instruction_o,
  output logic        inst_addr_misaligned_o,
  output logic        inst_access_fault_o
);
  ifid_t ifid_d, ifid_q, in_w;
  assign in_w = {pc_i, instruction_i, inst_addr_misaligned_i, inst_access_fault_i};
  always_comb ifid_d = flush ? BUBBLE : stall ? ifid_q : in_w;
  always_ff @(posedge clk) begin
    if (rst) ifid_q <= BUBBLE;
    else ifid_q <= ifid_d;
  end
  assign pc_o = ifid_q.pc;
  assign instruction_o = ifid_q.instr;
  assign inst_addr_misaligned_o = ifid_q.mis;
  assign inst_access_fault_o = ifid_q.fault;
endmodule

// File: rtl/titan_if_stage.sv
// titan_if_stage: instruction fetch stage with redirect/abort handling and a one-word skid buffer.
// Define TITAN_IF_ACCESS_FAULT_EN to turn iport_err_i into an instruction access fault.
module titan_if_stage
  import titan_if_stage_pkg::*;
#(
  parameter logic [31:0] RESET_ADDR = DEFAULT_RESET_ADDR
) (
  input  logic        clk_i,
  input  logic        rst_i,
  output logic [31:0] iport_addr_o,
  output logic        iport_cyc_o,
  output logic        iport_stb_o,
  input  logic [31:0] iport_data_i,
  input  logic        iport_ack_i,
  input  logic        iport_err_i,
  input  logic        take_branch_i,
  input  logic        take_jump_i,
  input  logic [31:0] pc_branch_address_i,
  input  logic [31:0] pc_jump_address_i,
  input  logic        if_exception_i,
  input  logic [31:0] if_exception_pc_i,
  input  logic        id_stall_i,
  input  logic        id_flush_i,
  output logic [31:0] id_pc_o,
  output logic [31:0] id_instruction_o,
  output logic        id_inst_addr_misaligned_o,
  output logic        id_inst_access_fault_o,
  output logic        if_busy_o
);
  if_state_e state_q, state_d;
  logic [31:0] pc_q, pc_d, tgt_q, tgt_d, skid_q, skid_d;
  logic skid_fault_q, skid_fault_d;
  logic err, redir, done, go, deliver, wfault;
  logic [31:0] target, go_pc, word;
  ifid_t if_in;
`ifdef TITAN_IF_ACCESS_FAULT_EN
  assign err = iport_err_i;
`else
  logic unused_err;
  assign unused_err = iport_err_i;
  assign err = 1'b0;
`endif
  assign redir = if_exception_i | (~id_stall_i & (take_jump_i | take_branch_i));
  assign target = if_exception_i ? if_exception_pc_i : take_jump_i ? pc_jump_address_i : pc_branch_address_i;
  assign done = iport_ack_i | err;
  always_comb begin
    state_d = state_q;
    pc_d = pc_q;
    tgt_d = tgt_q;
    skid_d = skid_q;
    skid_fault_d = skid_fault_q;
    go = 1'b0;
    go_pc = target;
    deliver = 1'b0;
    word = skid_q;
    wfault = skid_fault_q;
    if_in = BUBBLE;
    case (state_q)
      S_FETCH: begin
        word = iport_ack_i ? iport_data_i : NOP;
        wfault = ~iport_ack_i;
        go = done & redir;
        deliver = done & ~redir & ~id_stall_i;
        if (done & ~redir & id_stall_i) begin
          skid_d = word;
          skid_fault_d = wfault;
          state_d = S_HOLD;
        end
        if (~done & redir) begin
          tgt_d = target;
          state_d = S_ABORT;
        end
      end
      S_HOLD: begin
        go = redir;
        deliver = ~redir & ~id_stall_i;
      end
      // the stale response still has to terminate; the newest redirect wins
      S_ABORT: begin
        tgt_d = redir ? target : tgt_q;
        go = done;
        go_pc = tgt_d;
      end
      S_MISALIGN: begin
        go = redir;
        if (!redir) if_in = '{pc: pc_q, instr: NOP, mis: 1'b1, fault: 1'b0};
      end
      default: go = redir;
    endcase
    if (deliver) begin
      if_in = '{pc: pc_q, instr: word, mis: 1'b0, fault: wfault};
      pc_d = wfault ? pc_q : pc_q + 32'd4;
      state_d = wfault ? S_IDLE : S_FETCH;
    end
    if (go) begin
      pc_d = go_pc;
      state_d = entry_state(go_pc);
    end
  end
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= S_FETCH;
      pc_q <= RESET_ADDR;
      tgt_q <= '0;
      skid_q <= NOP;
      skid_fault_q <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q <= pc_d;
      tgt_q <= tgt_d;
      skid_q <= skid_d;
      skid_fault_q <= skid_fault_d;
    end
  end
  assign iport_addr_o = pc_q;
  assign if_busy_o = (state_q == S_FETCH) || (state_q == S_ABORT);
  assign iport_cyc_o = if_busy_o & ~rst_i;
  assign iport_stb_o = iport_cyc_o;
  titan_ifid_register u_ifid (
    .clk                    (clk_i),
    .rst                    (rst_i),
    .stall                  (id_stall_i),
    .flush                  (id_flush_i),
    .pc_i                   (if_in.pc),
    .instruction_i          (if_in.instr),
    .inst_addr_misaligned_i (if_in.mis),
    .inst_access_fault_i    (if_in.fault),
    .pc_o                   (id_pc_o),
    .instruction_o          (id_instruction_o),
    .inst_addr_misaligned_o (id_inst_addr_misaligned_o),
    .inst_access_fault_o    (id_inst_access_fault_o)
  );
endmodule
